// File: rtl/prog_store.sv
// rtl/prog_store.sv - program word store: valid/ready loader, registered fetch responder, core reset control
// Optional XOR checksum of loaded words enabled by `define PROG_STORE_CSUM_EN.
module prog_store #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    input  logic [ADDR_W-1:0] prog_addr_i,
    output logic [DATA_W-1:0] prog_data_o,
    output logic              prog_valid_o,
    input  logic              halt_i,
    output logic              core_n_rst_o
`ifdef PROG_STORE_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]   prog_data_q, prog_data_d;
    logic                prog_valid_q, prog_valid_d;
    logic                core_n_rst_q, core_n_rst_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                beat;

    assign load_ready_o = (state_q == LOAD) && !load_start_i;
    assign load_done_o  = (state_q == RUN) || (state_q == HALTED);
    assign beat         = load_valid_i && load_ready_o;
    assign prog_data_o  = prog_data_q;
    assign prog_valid_o = prog_valid_q;
    assign core_n_rst_o = core_n_rst_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        prog_data_d  = prog_data_q;
        prog_valid_d = 1'b0;
        core_n_rst_d = core_n_rst_q;
        case (state_q)
            IDLE: core_n_rst_d = 1'b0;
            LOAD: begin
                if (beat) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // Core leaves reset on the same edge that lands the final word.
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d      = RUN;
                        core_n_rst_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (halt_i) begin
                    state_d = HALTED;
                end else begin
                    prog_data_d  = mem_q[prog_addr_i];
                    prog_valid_d = 1'b1;
                end
            end
            HALTED: ;
            default: state_d = IDLE;
        endcase
        if (load_start_i) begin
            state_d      = LOAD;
            wr_ptr_d     = '0;
            prog_data_d  = prog_data_q;
            prog_valid_d = 1'b0;
            core_n_rst_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            prog_data_q  <= '0;
            prog_valid_q <= 1'b0;
            core_n_rst_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_data_q  <= prog_data_d;
            prog_valid_q <= prog_valid_d;
            core_n_rst_q <= core_n_rst_d;
        end
    end

    // Storage is deliberately unreset; a program is only ever read after a full load.
    always_ff @(posedge clk_i) begin
        if (beat) begin
            mem_q[wr_ptr_q] <= load_data_i;
        end
    end

`ifdef PROG_STORE_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (beat) begin
            csum_d = csum_q ^ load_data_i;
        end
        if (load_start_i) begin
            csum_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;
`endif

endmodule
